// File: rtl/sw_event_scheduler.sv
// sw_event_scheduler: synchronizes 4 switches, captures their rising edges and offers them round-robin as events
// Ports: clk, rst (async active-high) | sw raw switch levels | ev_valid/ev_id/ev_ready event handshake
//        pend captured-but-ungranted edges | ovf sticky flags for edges that hit an already pending requester
module sw_event_scheduler #(
    parameter int GAP_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [1:0] ev_id,
    output logic [3:0] pend,
    output logic [3:0] ovf
);
    typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;
    localparam logic [3:0] GAP_N = 4'(GAP_CYC);
    state_t     state;
    logic [3:0] s1, s2, prv, rise, clr, cnt;
    logic [1:0] ptr, sel;
    logic       grant;
    always_comb begin
        sel = ptr;
        for (int k = 3; k >= 0; k--) sel = pend[ptr + 2'(k)] ? ptr + 2'(k) : sel;
        grant = state == IDLE && |pend;
        clr = grant ? 4'b0001 << sel : 4'b0000;
        rise = s2 & ~prv;
    end
    // an edge landing on the grant edge re-arms pend instead of counting as overflow
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            prv <= '0;
            pend <= '0;
            ovf <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
            prv <= s2;
            pend <= (pend & ~clr) | rise;
            ovf <= ovf | (rise & pend & ~clr);
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            ev_valid <= 1'b0;
            ev_id <= '0;
            ptr <= '0;
            cnt <= '0;
        end else
            case (state)
                IDLE:
                    if (grant) begin
                        state <= OFFER;
                        ev_valid <= 1'b1;
                        ev_id <= sel;
                        ptr <= sel + 2'd1;
                    end
                OFFER:
                    if (ev_ready) begin
                        ev_valid <= 1'b0;
                        cnt <= GAP_N;
                        state <= GAP_N == 4'd0 ? IDLE : GAP;
                    end
                GAP: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_sw_event_scheduler.sv
// tb_sw_event_scheduler: directed vector table plus hand-written corner sequences for sw_event_scheduler
module tb_sw_event_scheduler;
    logic       clk = 1'b0, rst = 1'b0, ev_ready = 1'b0, ev_valid;
    logic [3:0] sw = '0, pend, ovf;
    logic [1:0] ev_id;
    int         tests = 0, fails = 0, n, bad;
    logic [1:0] ids [4];
    typedef struct {
        bit         r;
        logic [3:0] sw;
        logic       rdy;
        logic [10:0] exp;
    } vec_t;
    vec_t tbl [25];
    always #5 clk = ~clk;
    sw_event_scheduler #(.GAP_CYC(2)) dut (
        .clk(clk), .rst(rst), .sw(sw), .ev_ready(ev_ready),
        .ev_valid(ev_valid), .ev_id(ev_id), .pend(pend), .ovf(ovf)
    );
    function automatic vec_t mk(input bit r, input logic [3:0] s, input logic rdy,
                                input logic v, input logic [1:0] id, input logic [3:0] p, input logic [3:0] o);
        mk = '{r, s, rdy, {v, id, p, o}};
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic do_reset(input logic [3:0] s, input logic r);
        @(negedge clk);
        rst = 1'b1;
        sw = s;
        ev_ready = r;
        #1 chk("reset_state", {ev_valid, ev_id, pend, ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        tbl[0]  = mk(1, 4'b0001, 1, 0, 2'd0, 4'b0000, 4'b0000);
        tbl[1]  = mk(0, 4'b0001, 1, 0, 2'd0, 4'b0000, 4'b0000);
        tbl[2]  = mk(0, 4'b0001, 1, 0, 2'd0, 4'b0001, 4'b0000);
        tbl[3]  = mk(0, 4'b0001, 1, 1, 2'd0, 4'b0000, 4'b0000);
        tbl[4]  = mk(0, 4'b0001, 1, 0, 2'd0, 4'b0000, 4'b0000);
        tbl[5]  = mk(0, 4'b0001, 1, 0, 2'd0, 4'b0000, 4'b0000);
        tbl[6]  = mk(0, 4'b0001, 1, 0, 2'd0, 4'b0000, 4'b0000);
        tbl[7]  = mk(0, 4'b0001, 1, 0, 2'd0, 4'b0000, 4'b0000);
        tbl[8]  = mk(1, 4'b1111, 1, 0, 2'd0, 4'b0000, 4'b0000);
        tbl[9]  = mk(0, 4'b1111, 1, 0, 2'd0, 4'b0000, 4'b0000);
        tbl[10] = mk(0, 4'b1111, 1, 0, 2'd0, 4'b1111, 4'b0000);
        tbl[11] = mk(0, 4'b1111, 1, 1, 2'd0, 4'b1110, 4'b0000);
        tbl[12] = mk(0, 4'b1111, 1, 0, 2'd0, 4'b1110, 4'b0000);
        tbl[13] = mk(0, 4'b1111, 1, 0, 2'd0, 4'b1110, 4'b0000);
        tbl[14] = mk(0, 4'b1111, 1, 0, 2'd0, 4'b1110, 4'b0000);
        tbl[15] = mk(0, 4'b1111, 1, 1, 2'd1, 4'b1100, 4'b0000);
        tbl[16] = mk(0, 4'b1111, 1, 0, 2'd1, 4'b1100, 4'b0000);
        tbl[17] = mk(0, 4'b1111, 1, 0, 2'd1, 4'b1100, 4'b0000);
        tbl[18] = mk(0, 4'b1111, 1, 0, 2'd1, 4'b1100, 4'b0000);
        tbl[19] = mk(0, 4'b1111, 1, 1, 2'd2, 4'b1000, 4'b0000);
        tbl[20] = mk(0, 4'b1111, 1, 0, 2'd2, 4'b1000, 4'b0000);
        tbl[21] = mk(0, 4'b1111, 1, 0, 2'd2, 4'b1000, 4'b0000);
        tbl[22] = mk(0, 4'b1111, 1, 0, 2'd2, 4'b1000, 4'b0000);
        tbl[23] = mk(0, 4'b1111, 1, 1, 2'd3, 4'b0000, 4'b0000);
        tbl[24] = mk(0, 4'b1111, 1, 0, 2'd3, 4'b0000, 4'b0000);
        for (int i = 0; i < 25; i++) begin
            if (tbl[i].r) do_reset(tbl[i].sw, tbl[i].rdy);
            else begin
                sw = tbl[i].sw;
                ev_ready = tbl[i].rdy;
            end
            step;
            chk($sformatf("vec%0d", i), {ev_valid, ev_id, pend, ovf}, tbl[i].exp);
        end
        do_reset(4'b0100, 1'b0);
        repeat (4) step;
        chk("bp_offer", {ev_valid, ev_id}, {1'b1, 2'd2});
        bad = 0;
        repeat (10) begin
            step;
            if (!(ev_valid === 1'b1 && ev_id === 2'd2)) bad++;
        end
        chk("bp_stable", bad, 0);
        ev_ready = 1'b1;
        step;
        chk("bp_accept", ev_valid, 0);
        n = 0;
        repeat (12) begin
            step;
            n += int'(ev_valid);
        end
        chk("bp_single", n, 0);
        do_reset(4'b0001, 1'b0);
        repeat (4) step;
        chk("ovf_offer0", {ev_valid, ev_id}, {1'b1, 2'd0});
        repeat (2) begin
            sw = 4'b0101;
            repeat (4) step;
            sw = 4'b0001;
            repeat (4) step;
        end
        chk("ovf_flags", {pend, ovf}, {4'b0100, 4'b0100});
        chk("ovf_hold", {ev_valid, ev_id}, {1'b1, 2'd0});
        ev_ready = 1'b1;
        n = 0;
        repeat (20) begin
            if (ev_valid === 1'b1) begin
                if (n < 4) ids[n] = ev_id;
                n++;
            end
            step;
        end
        chk("ovf_count", n, 2);
        chk("ovf_ids", {ids[0], ids[1]}, {2'd0, 2'd2});
        chk("ovf_sticky", {pend, ovf}, {4'b0000, 4'b0100});
        do_reset(4'b0001, 1'b0);
        repeat (4) step;
        sw = 4'b0011;
        repeat (4) step;
        sw = 4'b0001;
        repeat (4) step;
        chk("col_pend", {ev_valid, ev_id, pend}, {1'b1, 2'd0, 4'b0010});
        ev_ready = 1'b1;
        step;
        ev_ready = 1'b0;
        sw = 4'b0011;
        chk("col_accept", ev_valid, 0);
        repeat (3) step;
        chk("col_grant", {ev_valid, ev_id, pend, ovf}, {1'b1, 2'd1, 4'b0010, 4'b0000});
        ev_ready = 1'b1;
        step;
        chk("col_accept1", ev_valid, 0);
        ev_ready = 1'b0;
        repeat (3) step;
        chk("col_second", {ev_valid, ev_id, pend, ovf}, {1'b1, 2'd1, 4'b0000, 4'b0000});
        do_reset(4'b0001, 1'b0);
        repeat (4) step;
        sw = 4'b1011;
        repeat (3) step;
        chk("rst_pend", {ev_valid, pend}, {1'b1, 4'b1010});
        #2 rst = 1'b1;
        sw = 4'b0000;
        #1 chk("rst_async", {ev_valid, ev_id, pend, ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (20) begin
            step;
            n += int'(ev_valid);
        end
        chk("rst_quiet", n, 0);
        do_reset(4'b0010, 1'b1);
        n = 0;
        repeat (20) begin
            step;
            n += int'(ev_valid);
        end
        chk("rst_held_one", n, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sw_event_scheduler.md
SW_EVENT_SCHEDULER -- requirements
Module: sw_event_scheduler

Interface
REQ-001 Parameter: GAP_CYC, default 2, idle cycles inserted after each accepted event (legal range 0..15).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: sw  input  4  raw switch/button levels, asynchronous to clk, one requester per bit.
REQ-005 Port: ev_ready  input  1  consumer accepts the offered event when high with ev_valid.
REQ-006 Port: ev_valid  output  1  registered; an event is offered on ev_id.
REQ-007 Port: ev_id  output  2  registered; index of the requester whose rising edge is offered.
REQ-008 Port: pend  output  4  registered; per-requester captured, not yet granted event.
REQ-009 Port: ovf  output  4  registered, sticky; an edge arrived while that requester's pend was already set.

Function
REQ-010 Each sw bit SHALL pass a 2-flop synchronizer (s1, s2) followed by a previous-value flop (prv); rise[i] = s2[i] & ~prv[i].
REQ-011 sw[i] going high before rising edge E0 and held SHALL give rise[i]=1 between E1 and E2, pend[i]=1 after E2; one event per low-to-high transition, none for a held level.
REQ-012 FSM states: IDLE, OFFER, GAP; ev_valid=1 only in OFFER.
REQ-013 IDLE with pend!=0: select first set bit scanning ptr, ptr+1, ... mod 4; at that edge load ev_id, clear that pend bit, go OFFER, set ptr=(granted id+1) mod 4.
REQ-014 IDLE with pend==0: stay IDLE, ev_id holds last value.
REQ-015 OFFER: ev_id and ev_valid SHALL hold stable until ev_ready=1 is sampled; no timeout.
REQ-016 OFFER with ev_ready=1: if GAP_CYC>0 go GAP loading gap counter with GAP_CYC, else go IDLE.
REQ-017 GAP: decrement counter each cycle; go IDLE on the edge where it goes 1->0; exactly GAP_CYC cycles spent in GAP.
REQ-018 rise[i] with pend[i]=0 SHALL set pend[i], in any state.
REQ-019 rise[i] with pend[i]=1 and pend[i] not being cleared this edge SHALL keep pend[i]=1 and set ovf[i]=1.
REQ-020 rise[i] on the same edge pend[i] is cleared by a grant SHALL leave pend[i]=1, ovf[i] unchanged (new event, not lost).
REQ-021 Events captured during OFFER or GAP SHALL wait in pend; minimum grant-to-grant spacing is 1 (OFFER) + GAP_CYC + 1 (IDLE) cycles.
REQ-022 Best-case latency: sw high before E0 -> ev_valid=1 after E3.
REQ-023 ovf bits SHALL clear only on rst.

Reset
REQ-024 rst=1 SHALL immediately force: s1, s2, prv, pend, ovf = 0; ev_valid=0; ev_id=0; ptr=0; gap counter=0; state IDLE.
REQ-025 Reset mid-OFFER or mid-GAP SHALL drop the offered event and all pending events without any ev_valid glitch.
REQ-026 sw[i] held high across reset release SHALL produce exactly one event for i (synchronizer resets to 0).

Verification
REQ-027 Single: sw=0001 before E0, ev_ready=1 -> pend=0001 after E2, ev_valid=1 ev_id=0 after E3, ev_valid=0 after E4, GAP for 2 cycles, IDLE.
REQ-028 Round-robin: sw 0000->1111 at once, ev_ready=1 -> ev_id sequence 0,1,2,3, each grant 4 cycles apart (GAP_CYC=2); no ovf.
REQ-029 Backpressure: ev_ready=0 for 10 cycles during OFFER -> ev_valid, ev_id stable all 10 cycles; one accept on ev_ready=1.
REQ-030 Overflow: ev_ready=0, pulse sw[2] twice (each high/low 4 cycles) while id 2 pending -> ovf=0100, pend[2]=1, single event for id 2 delivered.
REQ-031 Grant/edge collision: rise[1] on the grant edge of id 1 -> pend[1] stays 1, second id-1 event offered later, ovf[1]=0.
REQ-032 Reset: assert rst mid-OFFER with pend=1010 -> all outputs 0 immediately; after release with sw=0000 no ev_valid for 20 cycles.
